// File: rtl/raster_scan_counter.sv
// 2-D raster (col,row) address generator with run-time bounds, valid/ready handshake and frame markers.
// Optional build macro RASTER_CONTINUOUS_EN: frames repeat back-to-back without returning to DONE.
module raster_scan_counter #(
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [X_WIDTH-1:0]    x_last_i,
  input  logic [Y_WIDTH-1:0]    y_last_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [X_WIDTH-1:0]    x_o,
  output logic [Y_WIDTH-1:0]    y_o,
  output logic                  sol_o,
  output logic                  eol_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [FCNT_WIDTH-1:0] frame_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_p0;
  logic [X_WIDTH-1:0]    x_p0;
  logic [Y_WIDTH-1:0]    y_p0;
  logic [X_WIDTH-1:0]    x_last_p0;
  logic [Y_WIDTH-1:0]    y_last_p0;
  logic [FCNT_WIDTH-1:0] fcnt_p0;
  logic                  done_p0;
  logic                  vld_p0;
  logic                  beat;
  logic                  x_at_last;
  logic                  y_at_last;

  assign vld_p0    = (state_p0 == ST_RUN);
  assign beat      = vld_p0 & ready_i;
  assign x_at_last = (x_p0 == x_last_p0);
  assign y_at_last = (y_p0 == y_last_p0);

  // Stage p0: state, coordinate counters, latched bounds and frame counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p0  <= ST_IDLE;
      x_p0      <= '0;
      y_p0      <= '0;
      x_last_p0 <= '0;
      y_last_p0 <= '0;
      fcnt_p0   <= '0;
      done_p0   <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      if (abort_i) begin
        state_p0 <= ST_IDLE;
        x_p0     <= '0;
        y_p0     <= '0;
      end else if (start_i && (state_p0 != ST_RUN)) begin
        state_p0  <= ST_RUN;
        x_p0      <= '0;
        y_p0      <= '0;
        x_last_p0 <= x_last_i;
        y_last_p0 <= y_last_i;
      end else if (beat) begin
        if (!x_at_last) begin
          x_p0 <= x_p0 + 1'b1;
        end else if (!y_at_last) begin
          x_p0 <= '0;
          y_p0 <= y_p0 + 1'b1;
        end else begin
          x_p0    <= '0;
          y_p0    <= '0;
          fcnt_p0 <= fcnt_p0 + 1'b1;
          done_p0 <= 1'b1;
`ifdef RASTER_CONTINUOUS_EN
          // Next frame starts immediately with freshly sampled bounds
          x_last_p0 <= x_last_i;
          y_last_p0 <= y_last_i;
`else
          state_p0 <= ST_DONE;
`endif
        end
      end
    end
  end

  assign valid_o     = vld_p0;
  assign busy_o      = vld_p0;
  assign x_o         = x_p0;
  assign y_o         = y_p0;
  assign done_o      = done_p0;
  assign frame_cnt_o = fcnt_p0;
  assign sol_o       = vld_p0 & (x_p0 == '0);
  assign eol_o       = vld_p0 & x_at_last;
  assign sof_o       = sol_o & (y_p0 == '0);
  assign eof_o       = eol_o & y_at_last;

endmodule

// File: tb/tb_raster_scan_counter.sv
// Directed, table-driven bench for raster_scan_counter; honours RASTER_CONTINUOUS_EN when defined.
module tb_raster_scan_counter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       abort_i;
  logic [9:0] x_last_i;
  logic [8:0] y_last_i;
  logic       ready_i;
  logic       valid_o;
  logic [9:0] x_o;
  logic [8:0] y_o;
  logic       sol_o, eol_o, sof_o, eof_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] frame_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  raster_scan_counter #(.X_WIDTH(10), .Y_WIDTH(9), .FCNT_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .x_last_i(x_last_i), .y_last_i(y_last_i), .ready_i(ready_i),
    .valid_o(valid_o), .x_o(x_o), .y_o(y_o),
    .sol_o(sol_o), .eol_o(eol_o), .sof_o(sof_o), .eof_o(eof_o),
    .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       start;
    logic       ready;
    logic       evalid;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [3:0] emk;
    logic       edone;
    logic [7:0] efc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] marks();
    return {sol_o, eol_o, sof_o, eof_o};
  endfunction

  task automatic chk_idle(input string tag, input logic [7:0] efc);
    chk({tag, " valid"}, valid_o, 0);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " x"}, x_o, 0);
    chk({tag, " y"}, y_o, 0);
    chk({tag, " marks"}, marks(), 0);
    chk({tag, " done"}, done_o, 0);
    chk({tag, " fcnt"}, frame_cnt_o, efc);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 0; abort_i = 0; ready_i = 0; x_last_i = 0; y_last_i = 0;
    #1;
    chk_idle("reset", 0);
    step(); step();
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    logic r;
    do_reset();

`ifdef RASTER_CONTINUOUS_EN
    // 2x2 frames repeat back to back; done pulses on the first beat of each new frame
    x_last_i = 1; y_last_i = 1; ready_i = 1; start_i = 1;
    step();
    start_i = 0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("cont[%0d] valid", k), valid_o, 1);
      chk($sformatf("cont[%0d] x", k), x_o, k % 2);
      chk($sformatf("cont[%0d] y", k), y_o, (k / 2) % 2);
      chk($sformatf("cont[%0d] done", k), done_o, (k >= 4 && (k % 4) == 0));
      chk($sformatf("cont[%0d] fcnt", k), frame_cnt_o, k / 4);
      step();
    end
    #2 rst_i = 1'b1;
    #1;
    chk_idle("cont rst", 0);
    step();
    rst_i = 1'b0;
    abort_i = 0;
`else
    // Test 1: 4x3 frame, ready held high, checked against the table
    x_last_i = 3; y_last_i = 2;
    tbl[0] = '{start:1, ready:1, evalid:0, ex:0, ey:0, emk:0, edone:0, efc:0};
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 4; cc++)
        tbl[1 + rr*4 + cc] = '{start:0, ready:1, evalid:1, ex:cc, ey:rr,
                               emk:{cc == 0, cc == 3, cc == 0 && rr == 0, cc == 3 && rr == 2},
                               edone:0, efc:0};
    tbl[13] = '{start:0, ready:1, evalid:0, ex:0, ey:0, emk:0, edone:1, efc:1};
    tbl[14] = '{start:0, ready:1, evalid:0, ex:0, ey:0, emk:0, edone:0, efc:1};
    for (int i = 0; i < 15; i++) begin
      start_i = tbl[i].start;
      ready_i = tbl[i].ready;
      chk($sformatf("t1[%0d] valid", i), valid_o, tbl[i].evalid);
      chk($sformatf("t1[%0d] busy", i), busy_o, tbl[i].evalid);
      chk($sformatf("t1[%0d] x", i), x_o, tbl[i].ex);
      chk($sformatf("t1[%0d] y", i), y_o, tbl[i].ey);
      chk($sformatf("t1[%0d] marks", i), marks(), tbl[i].emk);
      chk($sformatf("t1[%0d] done", i), done_o, tbl[i].edone);
      chk($sformatf("t1[%0d] fcnt", i), frame_cnt_o, tbl[i].efc);
      step();
    end

    // Test 2: same frame with random backpressure; coordinates hold while ready is low
    start_i = 1; ready_i = 0;
    step();
    start_i = 0;
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < 12; cyc++) begin
      chk($sformatf("t2[%0d] valid", cyc), valid_o, 1);
      chk($sformatf("t2[%0d] x", cyc), x_o, idx % 4);
      chk($sformatf("t2[%0d] y", cyc), y_o, idx / 4);
      r = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ready_i = r;
      step();
      if (r) idx++;
    end
    chk("t2 beats", idx, 12);
    ready_i = 1;
    chk("t2 done", done_o, 1);
    chk("t2 valid", valid_o, 0);
    chk("t2 fcnt", frame_cnt_o, 2);

    // Test 3: 1x1 frames, all markers at once, counter wrap
    x_last_i = 0; y_last_i = 0; start_i = 1;
    step();
    start_i = 0;
    chk("t3 valid", valid_o, 1);
    chk("t3 marks", marks(), 4'hF);
    step();
    chk("t3 done", done_o, 1);
    chk("t3 fcnt", frame_cnt_o, 3);
    for (int f = 3; f < 255; f++) begin
      start_i = 1; step();
      start_i = 0; step();
    end
    chk("t3 fcnt255", frame_cnt_o, 255);
    start_i = 1; step();
    start_i = 0; step();
    chk("t3 wrap fcnt", frame_cnt_o, 0);
    chk("t3 wrap done", done_o, 1);

    // Test 4: abort on the fifth beat of a 4x3 frame
    x_last_i = 3; y_last_i = 2; start_i = 1;
    step();
    start_i = 0;
    for (int k = 0; k < 4; k++) step();
    chk("t4 pre x", x_o, 0);
    chk("t4 pre y", y_o, 1);
    chk("t4 pre valid", valid_o, 1);
    abort_i = 1;
    step();
    abort_i = 0;
    chk_idle("t4 abort", 0);
    step();
    chk("t4 idle valid", valid_o, 0);
    start_i = 1;
    step();
    start_i = 0;
    chk("t4 restart valid", valid_o, 1);
    chk("t4 restart marks", marks(), 4'b1010);
    chk("t4 restart x", x_o, 0);
    step();
    chk("t4 next x", x_o, 1);
    chk("t4 next y", y_o, 0);
    abort_i = 1;
    step();
    abort_i = 0;

    // Test 5: start held and bounds changed mid-frame are ignored
    x_last_i = 2; y_last_i = 1; start_i = 1;
    step();
    x_last_i = 5; y_last_i = 3;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t5[%0d] x", k), x_o, k % 3);
      chk($sformatf("t5[%0d] y", k), y_o, k / 3);
      chk($sformatf("t5[%0d] marks", k), marks(),
          {k % 3 == 0, k % 3 == 2, k == 0, k == 5});
      step();
    end
    start_i = 0;
    chk("t5 done", done_o, 1);
    chk("t5 valid", valid_o, 0);
    chk("t5 fcnt", frame_cnt_o, 1);

    // Test 6: async reset mid-frame
    x_last_i = 3; y_last_i = 2; start_i = 1;
    step();
    start_i = 0;
    step(); step();
    chk("t6 pre x", x_o, 2);
    #2 rst_i = 1'b1;
    #1;
    chk_idle("t6 rst", 0);
    step();
    chk("t6 no done", done_o, 0);
    rst_i = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
